// File: rtl/cache_plru_victim_sel_pkg.sv
// Shared definitions for the 4-way tree pseudo-LRU victim selector:
// way geometry, the per-set PLRU state record and the pure functions
// that update it, read a victim from it, and pick the first invalid way.
package cache_plru_victim_sel_pkg;

    localparam int NUM_WAYS = 4;
    localparam int WAY_W    = 2;

    // b0 picks the half (0: ways 0/1, 1: ways 2/3),
    // b1 picks within ways 0/1, b2 picks within ways 2/3.
    typedef struct packed {
        logic b0;
        logic b1;
        logic b2;
    } plru_state_t;

    localparam plru_state_t PLRU_RESET = '{b0: 1'b0, b1: 1'b0, b2: 1'b0};

    // Point every tree node on the path to 'way' away from it.
    // The node on the other subtree keeps its history.
    function automatic plru_state_t plru_update(plru_state_t state,
                                                logic [WAY_W-1:0] way);
        plru_state_t nxt;
        nxt    = state;
        nxt.b0 = ~way[1];
        if (way[1] == 1'b0) begin
            nxt.b1 = ~way[0];
        end else begin
            nxt.b2 = ~way[0];
        end
        return nxt;
    endfunction

    // Follow the tree pointers down to the pseudo-least-recently-used way.
    function automatic logic [WAY_W-1:0] plru_victim(plru_state_t state);
        logic [WAY_W-1:0] way;
        if (state.b0) begin
            way = {1'b1, state.b2};
        end else begin
            way = {1'b0, state.b1};
        end
        return way;
    endfunction

    // Lowest-numbered way whose valid bit is clear; 0 when all are valid
    // (the caller qualifies the result with any_invalid).
    function automatic logic [WAY_W-1:0] first_invalid(logic [NUM_WAYS-1:0] way_valid);
        logic [WAY_W-1:0] way;
        way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                way = WAY_W'(i);
            end
        end
        return way;
    endfunction

    function automatic logic any_invalid(logic [NUM_WAYS-1:0] way_valid);
        return ~(&way_valid);
    endfunction

endpackage

// File: rtl/cache_plru_set_state.sv
// Flop array holding the PLRU bits of every set. One write port for the
// hit/fill update, two combinational read ports: one feeds the
// read-modify-write of the update path, the other feeds victim selection.
module cache_plru_set_state
    import cache_plru_victim_sel_pkg::*;
#(
    parameter int NUM_SETS = 64,
    parameter int INDEX_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  plru_state_t        wr_state,
    input  logic [INDEX_W-1:0] rd_a_index,
    output plru_state_t        rd_a_state,
    input  logic [INDEX_W-1:0] rd_b_index,
    output plru_state_t        rd_b_state
);

    plru_state_t state_q [NUM_SETS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SETS; gi++) begin : gen_set
            plru_state_t state_reg;

            // Per-set PLRU bits; only the addressed set is written.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= PLRU_RESET;
                end else if (wr_en && (wr_index == INDEX_W'(gi))) begin
                    state_reg <= wr_state;
                end
            end

            assign state_q[gi] = state_reg;
        end
    endgenerate

    // Indices address the array directly; NUM_SETS is a power of two so
    // every index value is a legal set.
    assign rd_a_state = state_q[rd_a_index];
    assign rd_b_state = state_q[rd_b_index];

endmodule

// File: rtl/cache_plru_victim_sel.sv
// Tree pseudo-LRU victim selector for a 4-way set-associative cache.
// Hits and fills retarget the set's tree away from the touched way.
// A victim request returns a registered way one cycle later: the lowest
// invalid way if any exists, otherwise the PLRU choice. A same-cycle
// update to the requested set is forwarded into the victim decision.
module cache_plru_victim_sel
    import cache_plru_victim_sel_pkg::*;
#(
    parameter int NUM_SETS = 64,
    parameter int INDEX_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic [1:0]         upd_way,
    input  logic               vreq_valid,
    input  logic [INDEX_W-1:0] vreq_index,
    input  logic [3:0]         vreq_way_valid,
    output logic               vrsp_valid,
    output logic [1:0]         vrsp_way,
    output logic               vrsp_from_invalid
);

    plru_state_t upd_cur_state;
    plru_state_t upd_next_state;
    plru_state_t vreq_raw_state;
    plru_state_t vreq_state;

    logic             vrsp_valid_reg;
    logic [WAY_W-1:0] vrsp_way_reg;
    logic             vrsp_from_invalid_reg;
    logic [WAY_W-1:0] vrsp_way_next;
    logic             vrsp_from_invalid_next;

    cache_plru_set_state #(
        .NUM_SETS (NUM_SETS),
        .INDEX_W  (INDEX_W)
    ) u_set_state (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (upd_valid),
        .wr_index   (upd_index),
        .wr_state   (upd_next_state),
        .rd_a_index (upd_index),
        .rd_a_state (upd_cur_state),
        .rd_b_index (vreq_index),
        .rd_b_state (vreq_raw_state)
    );

    // New tree bits for the touched set; also the forwarding source.
    always_comb begin
        upd_next_state = plru_update(upd_cur_state, upd_way);
    end

    // Victim decision: forward this cycle's update when it hits the same
    // set, then let any invalid way override the PLRU choice.
    always_comb begin
        vreq_state             = vreq_raw_state;
        vrsp_way_next          = '0;
        vrsp_from_invalid_next = 1'b0;
        if (upd_valid && (upd_index == vreq_index)) begin
            vreq_state = upd_next_state;
        end
        if (any_invalid(vreq_way_valid)) begin
            vrsp_way_next          = first_invalid(vreq_way_valid);
            vrsp_from_invalid_next = 1'b1;
        end else begin
            vrsp_way_next          = plru_victim(vreq_state);
            vrsp_from_invalid_next = 1'b0;
        end
    end

    // Response registers: strobe every requested cycle, payload held
    // between requests. Reset drops any request still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vrsp_valid_reg        <= 1'b0;
            vrsp_way_reg          <= '0;
            vrsp_from_invalid_reg <= 1'b0;
        end else begin
            vrsp_valid_reg <= vreq_valid;
            if (vreq_valid) begin
                vrsp_way_reg          <= vrsp_way_next;
                vrsp_from_invalid_reg <= vrsp_from_invalid_next;
            end
        end
    end

    assign vrsp_valid        = vrsp_valid_reg;
    assign vrsp_way          = vrsp_way_reg;
    assign vrsp_from_invalid = vrsp_from_invalid_reg;

endmodule

// File: tb/tb_cache_plru_victim_sel.sv
// Self-checking bench for cache_plru_victim_sel. The reference model keeps,
// per set, which half the tree points at and which way of each pair it
// points at, and picks victims by walking that description directly.
module tb_cache_plru_victim_sel;

    localparam int NUM_SETS = 64;
    localparam int INDEX_W  = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               upd_valid;
    logic [INDEX_W-1:0] upd_index;
    logic [1:0]         upd_way;
    logic               vreq_valid;
    logic [INDEX_W-1:0] vreq_index;
    logic [3:0]         vreq_way_valid;
    logic               vrsp_valid;
    logic [1:0]         vrsp_way;
    logic               vrsp_from_invalid;

    int checks   = 0;
    int failures = 0;

    // Reference model: half_ptr = which pair (0 or 1) is older,
    // pair_ptr[s][p] = which member of pair p is older.
    int half_ptr [NUM_SETS];
    int pair_ptr [NUM_SETS][2];

    logic       exp_valid;
    logic [1:0] exp_way;
    logic       exp_fi;

    always #5 clk = ~clk;

    cache_plru_victim_sel #(
        .NUM_SETS (NUM_SETS),
        .INDEX_W  (INDEX_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .upd_valid         (upd_valid),
        .upd_index         (upd_index),
        .upd_way           (upd_way),
        .vreq_valid        (vreq_valid),
        .vreq_index        (vreq_index),
        .vreq_way_valid    (vreq_way_valid),
        .vrsp_valid        (vrsp_valid),
        .vrsp_way          (vrsp_way),
        .vrsp_from_invalid (vrsp_from_invalid)
    );

    function automatic void model_clear();
        for (int s = 0; s < NUM_SETS; s++) begin
            half_ptr[s]    = 0;
            pair_ptr[s][0] = 0;
            pair_ptr[s][1] = 0;
        end
    endfunction

    // Touching a way makes the other pair older, and its sibling older.
    function automatic void model_touch(int s, int w);
        int pair;
        pair           = w / 2;
        half_ptr[s]    = 1 - pair;
        pair_ptr[s][pair] = 1 - (w % 2);
    endfunction

    function automatic void model_pick(int s, logic [3:0] vv);
        int found;
        found = -1;
        for (int i = 3; i >= 0; i--) begin
            if (vv[i] == 1'b0) found = i;
        end
        if (found >= 0) begin
            exp_way = 2'(found);
            exp_fi  = 1'b1;
        end else begin
            exp_way = 2'(2 * half_ptr[s] + pair_ptr[s][half_ptr[s]]);
            exp_fi  = 1'b0;
        end
    endfunction

    // Drive one cycle of inputs (just after a rising edge), advance the
    // model the way the hardware should, and wait for the next edge + 1.
    task automatic cycle(input bit uv, input int ui, input int uw,
                         input bit rv, input int ri, input logic [3:0] vv);
        upd_valid      = uv;
        upd_index      = INDEX_W'(ui);
        upd_way        = 2'(uw);
        vreq_valid     = rv;
        vreq_index     = INDEX_W'(ri);
        vreq_way_valid = vv;
        if (uv) model_touch(ui, uw);
        if (rv) model_pick(ri, vv);
        exp_valid = rv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 0, 0, 1'b0, 0, 4'hF);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        upd_valid = 1'b0; upd_index = '0; upd_way = '0;
        vreq_valid = 1'b0; vreq_index = '0; vreq_way_valid = 4'hF;
        model_clear();
        exp_way = 2'd0; exp_fi = 1'b0; exp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (vrsp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", vrsp_valid);
        end
        checks++;
        if (vrsp_way !== 2'd0) begin
            failures++; $display("FAIL reset_way got=%0d exp=0", vrsp_way);
        end
        checks++;
        if (vrsp_from_invalid !== 1'b0) begin
            failures++; $display("FAIL reset_from_invalid got=%b exp=0", vrsp_from_invalid);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b0, 0, 0, 1'b1, 5, 4'b1111);
        checks++;
        if (vrsp_valid !== 1'b1 || vrsp_way !== 2'd0 || vrsp_from_invalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_req got v=%b w=%0d fi=%b exp v=1 w=0 fi=0",
                     vrsp_valid, vrsp_way, vrsp_from_invalid);
        end
        $display("test_reset: set5 req -> v=%b way=%0d fi=%b", vrsp_valid, vrsp_way, vrsp_from_invalid);
        idle();
        checks++;
        if (vrsp_valid !== 1'b0) begin
            failures++; $display("FAIL single_cycle_strobe got=%b exp=0", vrsp_valid);
        end
    endtask

    task automatic test_invalid_first();
        cycle(1'b0, 0, 0, 1'b1, 3, 4'b1011);
        checks++;
        if (vrsp_valid !== 1'b1 || vrsp_way !== 2'd2 || vrsp_from_invalid !== 1'b1) begin
            failures++;
            $display("FAIL invalid_1011 got v=%b w=%0d fi=%b exp v=1 w=2 fi=1",
                     vrsp_valid, vrsp_way, vrsp_from_invalid);
        end
        $display("test_invalid_first: set3 vv=1011 -> way=%0d fi=%b", vrsp_way, vrsp_from_invalid);
        idle();
        checks++;
        if (vrsp_valid !== 1'b0 || vrsp_way !== 2'd2 || vrsp_from_invalid !== 1'b1) begin
            failures++;
            $display("FAIL hold_after_1011 got v=%b w=%0d fi=%b exp v=0 w=2 fi=1",
                     vrsp_valid, vrsp_way, vrsp_from_invalid);
        end
        cycle(1'b0, 0, 0, 1'b1, 3, 4'b0000);
        checks++;
        if (vrsp_valid !== 1'b1 || vrsp_way !== 2'd0 || vrsp_from_invalid !== 1'b1) begin
            failures++;
            $display("FAIL invalid_0000 got v=%b w=%0d fi=%b exp v=1 w=0 fi=1",
                     vrsp_valid, vrsp_way, vrsp_from_invalid);
        end
        $display("test_invalid_first: set3 vv=0000 -> way=%0d fi=%b", vrsp_way, vrsp_from_invalid);
        // Every partially-valid pattern on a random set against the model.
        for (int p = 0; p < 15; p++) begin
            int s;
            s = $urandom_range(10, 63);
            cycle(1'b0, 0, 0, 1'b1, s, 4'(p));
            checks++;
            if (vrsp_valid !== 1'b1 || vrsp_way !== exp_way || vrsp_from_invalid !== exp_fi) begin
                failures++;
                $display("FAIL invalid_pattern vv=%b got v=%b w=%0d fi=%b exp v=1 w=%0d fi=%b",
                         4'(p), vrsp_valid, vrsp_way, vrsp_from_invalid, exp_way, exp_fi);
            end
        end
    endtask

    task automatic test_update_sequence();
        for (int w = 0; w < 4; w++) cycle(1'b1, 7, w, 1'b0, 0, 4'hF);
        cycle(1'b0, 0, 0, 1'b1, 7, 4'b1111);
        checks++;
        if (vrsp_valid !== 1'b1 || vrsp_way !== 2'd0 || vrsp_from_invalid !== 1'b0) begin
            failures++;
            $display("FAIL set7_seq got v=%b w=%0d fi=%b exp v=1 w=0 fi=0",
                     vrsp_valid, vrsp_way, vrsp_from_invalid);
        end
        $display("test_update_sequence: set7 after 0,1,2,3 -> way=%0d", vrsp_way);
        cycle(1'b1, 9, 0, 1'b0, 0, 4'hF);
        cycle(1'b0, 0, 0, 1'b1, 9, 4'b1111);
        checks++;
        if (vrsp_valid !== 1'b1 || vrsp_way !== 2'd2 || vrsp_from_invalid !== 1'b0) begin
            failures++;
            $display("FAIL set9_after_w0 got v=%b w=%0d fi=%b exp v=1 w=2 fi=0",
                     vrsp_valid, vrsp_way, vrsp_from_invalid);
        end
        $display("test_update_sequence: set9 after 0 -> way=%0d", vrsp_way);
        cycle(1'b1, 9, 2, 1'b0, 0, 4'hF);
        cycle(1'b0, 0, 0, 1'b1, 9, 4'b1111);
        checks++;
        if (vrsp_valid !== 1'b1 || vrsp_way !== 2'd1 || vrsp_from_invalid !== 1'b0) begin
            failures++;
            $display("FAIL set9_after_w2 got v=%b w=%0d fi=%b exp v=1 w=1 fi=0",
                     vrsp_valid, vrsp_way, vrsp_from_invalid);
        end
        $display("test_update_sequence: set9 after 0,2 -> way=%0d", vrsp_way);
    endtask

    task automatic test_forwarding();
        cycle(1'b1, 2, 0, 1'b1, 2, 4'b1111);
        checks++;
        if (vrsp_valid !== 1'b1 || vrsp_way !== 2'd2 || vrsp_from_invalid !== 1'b0) begin
            failures++;
            $display("FAIL forward_same_set got v=%b w=%0d fi=%b exp v=1 w=2 fi=0",
                     vrsp_valid, vrsp_way, vrsp_from_invalid);
        end
        $display("test_forwarding: upd set2 w0 + req set2 -> way=%0d", vrsp_way);
        cycle(1'b1, 2, 0, 1'b1, 4, 4'b1111);
        checks++;
        if (vrsp_valid !== 1'b1 || vrsp_way !== 2'd0 || vrsp_from_invalid !== 1'b0) begin
            failures++;
            $display("FAIL forward_other_set got v=%b w=%0d fi=%b exp v=1 w=0 fi=0",
                     vrsp_valid, vrsp_way, vrsp_from_invalid);
        end
        $display("test_forwarding: upd set2 w0 + req set4 -> way=%0d", vrsp_way);
    endtask

    task automatic test_back_to_back_random();
        int errs_before;
        errs_before = failures;
        for (int n = 0; n < 400; n++) begin
            bit         uv, rv;
            int         ui, uw, ri;
            logic [3:0] vv;
            uv = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 3) != 0);
            ui = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
            ri = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
            uw = $urandom_range(0, 3);
            vv = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            cycle(uv, ui, uw, rv, ri, vv);
            checks++;
            if (vrsp_valid !== exp_valid || vrsp_way !== exp_way || vrsp_from_invalid !== exp_fi) begin
                failures++;
                $display("FAIL random n=%0d upd=%b/%0d/%0d req=%b/%0d vv=%b got v=%b w=%0d fi=%b exp v=%b w=%0d fi=%b",
                         n, uv, ui, uw, rv, ri, vv, vrsp_valid, vrsp_way, vrsp_from_invalid,
                         exp_valid, exp_way, exp_fi);
            end
        end
        $display("test_back_to_back_random: 400 cycles, new failures=%0d", failures - errs_before);
    endtask

    task automatic test_reset_midflight();
        upd_valid      = 1'b0;
        vreq_valid     = 1'b1;
        vreq_index     = INDEX_W'(9);
        vreq_way_valid = 4'b1111;
        #2;
        rst = 1'b1;
        model_clear();
        exp_way = 2'd0; exp_fi = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (vrsp_valid !== 1'b0 || vrsp_way !== 2'd0 || vrsp_from_invalid !== 1'b0) begin
            failures++;
            $display("FAIL midflight_drop got v=%b w=%0d fi=%b exp v=0 w=0 fi=0",
                     vrsp_valid, vrsp_way, vrsp_from_invalid);
        end
        @(negedge clk);
        rst        = 1'b0;
        vreq_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (vrsp_valid !== 1'b0) begin
            failures++; $display("FAIL midflight_no_late_pulse got=%b exp=0", vrsp_valid);
        end
        $display("test_reset_midflight: request dropped, v=%b", vrsp_valid);
        cycle(1'b0, 0, 0, 1'b1, 9, 4'b1111);
        checks++;
        if (vrsp_valid !== 1'b1 || vrsp_way !== 2'd0 || vrsp_from_invalid !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_set9 got v=%b w=%0d fi=%b exp v=1 w=0 fi=0",
                     vrsp_valid, vrsp_way, vrsp_from_invalid);
        end
        for (int k = 0; k < 8; k++) begin
            int s;
            s = (k < 6) ? k : $urandom_range(0, 63);
            cycle(1'b0, 0, 0, 1'b1, s, 4'b1111);
            checks++;
            if (vrsp_valid !== 1'b1 || vrsp_way !== exp_way || vrsp_from_invalid !== 1'b0) begin
                failures++;
                $display("FAIL after_reset_set%0d got v=%b w=%0d fi=%b exp v=1 w=%0d fi=0",
                         s, vrsp_valid, vrsp_way, vrsp_from_invalid, exp_way);
            end
        end
    endtask

    initial begin
        test_reset();
        test_invalid_first();
        test_update_sequence();
        test_forwarding();
        test_back_to_back_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_plru_victim_sel.md
Name: cache_plru_victim_sel

Overview:
- Per-set tree pseudo-LRU replacement tracker for the 4-way set-associative write-back/write-allocate cache.
- Records every hit and every fill per set.
- On request from the cache controller, returns a registered 2-bit victim way. The way-select decoder expands that index into one-hot way write enables.
- Invalid ways always take priority over the PLRU choice, so cold sets fill before any eviction.

Parameters:
- NUM_SETS, 64, number of cache sets; must be a power of two.
- INDEX_W, 6, set-index width; equals log2(NUM_SETS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- upd_valid  input  1  a hit or fill touched a way this cycle.
- upd_index  input  INDEX_W  set index of the touched set.
- upd_way  input  2  way that was hit or filled.
- vreq_valid  input  1  request for a victim way.
- vreq_index  input  INDEX_W  set index for the victim request.
- vreq_way_valid  input  4  valid bits of the four ways in vreq_index; bit i is way i.
- vrsp_valid  output  1  victim response strobe; high for exactly one cycle.
- vrsp_way  output  2  chosen victim way; feeds the 2-to-4 way-select decoder.
- vrsp_from_invalid  output  1  victim was an invalid way, so no write-back check is needed.

Behaviour:
- State per set: 3 bits {b0, b1, b2}.
  - b0 selects the half: 0 = ways 0/1, 1 = ways 2/3.
  - b1 selects within ways 0/1: 0 = way 0, 1 = way 1.
  - b2 selects within ways 2/3: 0 = way 2, 1 = way 3.
  - Storage is a flop array of NUM_SETS x 3 bits; no SRAM.
- Reset:
  - All PLRU bits clear to 0.
  - vrsp_valid = 0, vrsp_way = 2'b00, vrsp_from_invalid = 0.
  - Reset is asynchronous and takes effect mid-operation. A request in flight is dropped with no response, and the controller must re-issue it.
- Update rule: when upd_valid = 1 with way w, make the bits point away from w on the next edge.
  - b0 <= ~w[1].
  - If w[1] = 0: b1 <= ~w[0], and b2 is unchanged.
  - If w[1] = 1: b2 <= ~w[0], and b1 is unchanged.
  - Other sets are untouched.
- Victim rule, when vreq_valid = 1:
  - If any bit of vreq_way_valid is 0, the victim is the lowest-numbered invalid way and vrsp_from_invalid = 1.
  - Otherwise, if b0 = 0 the victim is {0, b1}; if b0 = 1 the victim is {1, b2}; vrsp_from_invalid = 0.
- Latency and handshake:
  - The request is sampled on edge N, and vrsp_valid/vrsp_way/vrsp_from_invalid are valid during cycle N+1.
  - Requests may be issued back-to-back, one per cycle, with no stall.
  - vrsp_way and vrsp_from_invalid hold their last value while vrsp_valid = 0.
- Same-cycle update and request to the same set: the victim is computed from the post-update bits (forwarded). Update and request to different sets are independent.
- A victim request does not itself modify PLRU state. The controller issues upd_valid with the filled way when the fill completes.
- Index arithmetic: indices are used directly as array addresses, with no wrap logic needed since NUM_SETS is a power of two. Any X on an index while its valid is 0 is ignored.

Decomposition:
- Shared cache package:
  - NUM_WAYS = 4 and WAY_W = 2.
  - PLRU state typedef (3-bit struct b0/b1/b2).
  - Functions plru_update(state, way) and plru_victim(state).
  - The invalid-first priority-encoder function.
- One natural sub-module: cache_plru_set_state, the flop array with write port and combinational read port.
  - The top level keeps the forwarding mux, the invalid-first selection and the response registers.

Test Plan:
- Reset, then request set 5 with way_valid = 4'b1111 -> vrsp_valid one cycle later, vrsp_way = 0, vrsp_from_invalid = 0.
- Request set 3 with way_valid = 4'b1011 -> vrsp_way = 2, vrsp_from_invalid = 1.
- Request set 3 with way_valid = 4'b0000 -> vrsp_way = 0, vrsp_from_invalid = 1.
- Set 7, way_valid = 4'b1111, updates way 0, 1, 2, 3 in consecutive cycles, then request:
  - Resulting bits are b0 = 0, b1 = 0, b2 = 0.
  - Required response: vrsp_way = 0.
- Set 9, update way 0 followed by request -> bits b0 = 1, b1 = 1, b2 = 0, so vrsp_way = 2. Then update way 2 -> bits 0/1/1, so vrsp_way = 1.
- Same-cycle forwarding check on set 2 from reset state:
  - Update way 0 and request set 2 in the same cycle -> vrsp_way = 2, from post-update bits.
  - The same pair with the request on set 4 -> vrsp_way = 0, unaffected.
- Assert rst for one cycle while vreq_valid = 1 -> no vrsp_valid pulse, all PLRU bits back to 0, next request returns way 0.
